// File: rtl/escalonador_pkg.sv
// Shared types and constants for the round-robin program scheduler.
package escalonador_pkg;

  localparam int N_SLOTS   = 8;
  localparam int SLOT_SIZE = 200;
  localparam int QW        = 8;
  localparam int SLOT_W    = $clog2(N_SLOTS);

  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic [2:0] {
    RUN,
    SAVE,
    SELECT,
    LOAD,
    CAPTURE,
    RESUME
  } estado_t;

endpackage

// File: rtl/seletor_round_robin.sv
// Combinational next-active-slot finder: scans atual+1 upward with wrap,
// skipping slot 0, which is only chosen when no other slot is active.
module seletor_round_robin
  import escalonador_pkg::*;
(
  input  logic [N_SLOTS-1:0] ativos,
  input  slot_t              atual,
  output slot_t              prox
);

  logic  achou;
  slot_t idx;

  always_comb begin
    prox  = '0;
    achou = 1'b0;
    idx   = '0;
    // Offset N_SLOTS lands back on atual, so a lone active slot re-selects itself
    for (int k = 1; k <= N_SLOTS; k++) begin
      idx = slot_t'((int'(atual) + k) % N_SLOTS);
      if (!achou && idx != '0 && ativos[idx]) begin
        prox  = idx;
        achou = 1'b1;
      end
    end
  end

endmodule

// File: rtl/escalonador_programas.sv
// Round-robin time-slice scheduler: owns the active-slot table and quantum,
// sequences save/select/load/capture/resume. Optional macro: QUANTUM_CFG_EN.
module escalonador_programas
  import escalonador_pkg::*;
#(
  parameter int QUANTUM = 16
)
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               instr_done,
  input  logic               end_program,
  input  logic [31:0]        pc_atual,
  input  logic [31:0]        ram_q,
  input  logic               ativar,
  input  slot_t              ativar_slot,
  input  logic               cfg_we,
  input  logic [QW-1:0]      cfg_quantum,
  output logic               spc,
  output logic               lpc,
  output logic [31:0]        endereco_spc,
  output slot_t              programa,
  output logic [31:0]        base_slot,
  output logic [31:0]        pc_novo,
  output logic               pc_load,
  output logic               cpu_stall,
  output logic [N_SLOTS-1:0] ativos
);

  localparam logic [QW-1:0] QUANTUM_INI = QW'(QUANTUM);

  estado_t            estado_reg, estado_next;
  slot_t              programa_reg;
  slot_t              prox;
  logic [N_SLOTS-1:0] ativos_reg, ativos_next;
  logic [QW-1:0]      cnt_reg;
  logic [QW-1:0]      quantum_atual;
  logic               fim_reg;
  logic               mesmo_reg;
  logic [31:0]        pc_novo_reg;

`ifdef QUANTUM_CFG_EN
  logic [QW-1:0] quantum_reg;

  // Takes effect only at the next reload, never mid-slice
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      quantum_reg <= QUANTUM_INI;
    else if (cfg_we)
      quantum_reg <= (cfg_quantum == '0) ? QW'(1) : cfg_quantum;
  end

  assign quantum_atual = quantum_reg;
`else
  logic unused_cfg;
  assign unused_cfg    = cfg_we ^ (^cfg_quantum);
  assign quantum_atual = QUANTUM_INI;
`endif

  seletor_round_robin u_seletor (
    .ativos (ativos_reg),
    .atual  (programa_reg),
    .prox   (prox)
  );

  assign base_slot = 32'(programa_reg) * 32'(SLOT_SIZE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      estado_reg <= RUN;
    else
      estado_reg <= estado_next;
  end

  always_comb begin
    estado_next = estado_reg;
    case (estado_reg)
      RUN:     if (end_program || (instr_done && cnt_reg == QW'(1))) estado_next = SAVE;
      SAVE:    estado_next = SELECT;
      SELECT:  estado_next = (mesmo_reg || prox == programa_reg) ? RESUME : LOAD;
      LOAD:    estado_next = CAPTURE;
      CAPTURE: estado_next = RESUME;
      RESUME:  estado_next = RUN;
      default: estado_next = RUN;
    endcase
  end

  always_comb begin
    spc          = 1'b0;
    endereco_spc = '0;
    lpc          = 1'b0;
    pc_load      = 1'b0;
    cpu_stall    = (estado_reg != RUN);
    case (estado_reg)
      SAVE: begin
        // No save when the program ended or when no other slot will take over
        spc          = !fim_reg && (prox != programa_reg);
        endereco_spc = pc_atual;
      end
      LOAD:    lpc     = 1'b1;
      RESUME:  pc_load = 1'b1;
      default: ;
    endcase
  end

  // Activation and end-of-program clearing; clearing is applied last so it wins
  always_comb begin
    ativos_next = ativos_reg;
    if (ativar && ativar_slot != '0)
      ativos_next[ativar_slot] = 1'b1;
    if (estado_reg == SAVE && fim_reg && programa_reg != '0)
      ativos_next[programa_reg] = 1'b0;
    ativos_next[0] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      programa_reg <= '0;
      ativos_reg   <= N_SLOTS'(1);
      cnt_reg      <= QUANTUM_INI;
      fim_reg      <= 1'b0;
      mesmo_reg    <= 1'b0;
      pc_novo_reg  <= '0;
    end else begin
      ativos_reg <= ativos_next;
      case (estado_reg)
        RUN: begin
          if (instr_done && cnt_reg != '0)
            cnt_reg <= cnt_reg - QW'(1);
          if (estado_next == SAVE)
            fim_reg <= end_program;
        end
        // Latch the skip decision so SELECT never switches away without a save
        SAVE:    mesmo_reg <= !fim_reg && (prox == programa_reg);
        SELECT: begin
          if (estado_next == LOAD)
            programa_reg <= prox;
          else
            pc_novo_reg <= pc_atual;
        end
        CAPTURE: pc_novo_reg <= ram_q + base_slot;
        RESUME:  cnt_reg     <= quantum_atual;
        default: ;
      endcase
    end
  end

  assign programa = programa_reg;
  assign ativos   = ativos_reg;
  assign pc_novo  = pc_novo_reg;

endmodule
